result_writeback: RTL and testbench
===================================

# result_writeback

Drains deskewed systolic-array results back into the SRAM unified buffer. The array reads activations out of the unified buffer; this block closes the loop in the write direction. Each accepted result row (MATRIX_SIZE signed partial sums) is requantised to DATA_BW bits per lane and packed into one UB word. The word is buffered in a small FIFO and written to consecutive UB addresses from a programmed base, under a host grant so the host write path keeps priority.

## Interface
Parameters:
- PARTIAL_SUM_BW, 20, width of one signed partial sum
- DATA_BW, 8, width of one requantised lane
- MATRIX_SIZE, 8, lanes per row
- ADDRESSSIZE, 10, UB address width
- WORDSIZE, 64, UB word width; must equal DATA_BW*MATRIX_SIZE
- FIFO_DEPTH, 4, write-buffer entries (power of two)

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle job launch; latches base_addr, num_rows, shift
- base_addr  in  ADDRESSSIZE  first UB write address
- num_rows  in  ADDRESSSIZE+1  rows in the job (0..2^ADDRESSSIZE)
- shift  in  5  arithmetic right-shift amount (0..PARTIAL_SUM_BW-1)
- result_valid  in  1  result_data holds a complete deskewed row
- result_data  in  PARTIAL_SUM_BW*MATRIX_SIZE  lane i at bits [i*PSB +: PSB], signed
- ub_grant  in  1  host permits a write pop this edge
- ub_write_enable  out  1  registered UB write strobe
- ub_address  out  ADDRESSSIZE  registered UB address
- ub_data  out  WORDSIZE  registered packed word; lane i at [i*DATA_BW +: DATA_BW]
- busy  out  1  high from start until done
- done  out  1  one-cycle job-complete pulse
- overflow  out  1  sticky: a row was dropped; cleared by start or rst

## Operation
- FSM states: IDLE, ACTIVE, DRAIN, DONE.
- IDLE: on start, latch the job inputs, clear overflow, clear the row and write counters, then go to ACTIVE. If num_rows==0, go to DONE instead. result_valid is ignored in IDLE.
- ACTIVE: a row is accepted on each edge with result_valid=1. Once the accepted count reaches num_rows, go to DRAIN; further result_valid is ignored.
- DRAIN: stay until the quantiser stage and the FIFO are both empty, then go to DONE.
- DONE: assert done for one cycle, then go to IDLE. busy is low in IDLE only.
- start while busy is ignored.
- Requantise, per lane:
  - r = (p + (shift ? 1<<(shift-1) : 0)) >>> shift, computed at PARTIAL_SUM_BW+1 bits to avoid round overflow.
  - Saturate r to [-2^(DATA_BW-1), 2^(DATA_BW-1)-1].
- Pipeline: accept edge registers the quantised word (stage Q); the next edge pushes Q into the FIFO.
- Write: on an edge with ub_grant=1 and the FIFO non-empty, pop the head. ub_write_enable, ub_address and ub_data are registered from that pop. Otherwise ub_write_enable=0 and address/data hold.
- ub_address = base_addr + write index, wrapping modulo 2^ADDRESSSIZE.
- Overflow:
  - If the FIFO is full and Q is valid with no pop this edge, Q holds and the pipeline stalls.
  - A row accepted while Q is stalled is dropped: it still counts toward num_rows, and overflow is set.
- rst mid-job: returns to IDLE and empties the FIFO and Q. All outputs go to 0 and any in-flight rows are discarded.

## Timing
- Reset values: ub_write_enable=0, ub_address=0, ub_data=0, busy=0, done=0, overflow=0.
- Latency with ub_grant held high: row sampled at edge E0; Q valid after E0; FIFO push at E1; pop at E2. ub_write_enable is high in the cycle after E2, a 3-edge latency.
- Throughput: one row per cycle sustained while ub_grant=1.
- busy rises the cycle after start.
- done follows the final write by one cycle.
- Simultaneous push and pop with the FIFO full is legal and does not stall.

## Structure
- Shared package: the FSM state encoding and the requantise/saturate function (reused by any future activation unit).
- One sub-module, sync_fifo: parameterised width and depth, with full and empty flags and simultaneous push/pop support.

## Test plan
- base_addr=0x3FE, num_rows=4, shift=0, ub_grant=1, four rows of lanes 0..7 -> writes at 0x3FE, 0x3FF, 0x000, 0x001. ub_data=0x0706050403020100. done 1 cycle after the last write.
- shift=4, lane values 24, 23, -24, 40000, -40000 -> requantised 2, 1, -1, 127, -128. Checks round-half-up and saturation.
- num_rows=0 start -> busy for 2 cycles, done pulse, no writes.
- ub_grant=0 while 8 consecutive rows arrive -> FIFO fills and Q stalls. Rows 6..8 are dropped and overflow=1. Raise grant -> exactly 5 writes (FIFO entries plus Q), then done.
- rst asserted while 2 entries are buffered -> the next cycle shows all outputs 0 and busy=0. A new start runs cleanly with no stale writes.

Source files
------------

// File: rtl/result_writeback_pkg.sv
// Shared types and the requantise/saturate helper for array result paths.
package result_writeback_pkg;

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, DONE} wb_state_e;

  localparam int REQ_W = 32;

  // Round-half-up arithmetic shift evaluated one bit wider than the input,
  // then clamp to a signed data_bw-bit range. Caller truncates to data_bw.
  function automatic logic [REQ_W-1:0] requant(input logic [REQ_W-1:0] p,
                                               input logic [4:0]       sh,
                                               input int               data_bw);
    logic signed [REQ_W:0] r, rnd, hi, lo;
    rnd = (sh != 5'd0) ? (33'sd1 <<< (sh - 5'd1)) : '0;
    r   = $signed({p[REQ_W-1], p}) + rnd;
    r   = r >>> sh;
    hi  = (33'sd1 <<< (data_bw - 1)) - 33'sd1;
    lo  = ~hi;
    if (r > hi)      r = hi;
    else if (r < lo) r = lo;
    return r[REQ_W-1:0];
  endfunction

endpackage

// File: rtl/result_writeback_fifo.sv
// Synchronous FIFO with occupancy count; push while full is accepted when a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/result_writeback.sv
// Requantises systolic-array result rows and writes them to consecutive
// unified-buffer addresses through a small write FIFO under host grant.
module result_writeback
  import result_writeback_pkg::*;
#(
  parameter int PARTIAL_SUM_BW = 20,
  parameter int DATA_BW        = 8,
  parameter int MATRIX_SIZE    = 8,
  parameter int ADDRESSSIZE    = 10,
  parameter int WORDSIZE       = 64,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [ADDRESSSIZE-1:0]               base_addr,
  input  logic [ADDRESSSIZE:0]                 num_rows,
  input  logic [4:0]                           shift,
  input  logic                                 result_valid,
  input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] result_data,
  input  logic                                 ub_grant,
  output logic                                 ub_write_enable,
  output logic [ADDRESSSIZE-1:0]               ub_address,
  output logic [WORDSIZE-1:0]                  ub_data,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 overflow
);
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
  localparam int PSB = PARTIAL_SUM_BW;
  localparam logic [ADDRESSSIZE:0]   ROW_ONE = (ADDRESSSIZE+1)'(1);
  localparam logic [ADDRESSSIZE-1:0] IDX_ONE = ADDRESSSIZE'(1);

  typedef struct packed {
    logic [ADDRESSSIZE-1:0] base;
    logic [ADDRESSSIZE:0]   rows;
    logic [4:0]             shift;
  } job_t;

  wb_state_e              state;
  job_t                   job;
  logic [ADDRESSSIZE:0]   acc_cnt;
  logic [ADDRESSSIZE-1:0] wr_idx;

  logic                                q_vld;
  logic [WORDSIZE-1:0]                 q_data;
  logic [MATRIX_SIZE-1:0][DATA_BW-1:0] q_next;

  logic                fifo_full, fifo_empty;
  logic [FCW-1:0]      fifo_count;
  logic [WORDSIZE-1:0] fifo_dout;

  logic launch, accept, stall, push, pop, drain_empty;

  assign launch = (state == IDLE) && start;
  assign accept = (state == ACTIVE) && result_valid;
  assign pop    = ub_grant && !fifo_empty;
  assign stall  = q_vld && fifo_full && !pop;
  assign push   = q_vld && !stall;
  // Looks one edge ahead so done trails the last write strobe by one cycle.
  assign drain_empty = !q_vld && (fifo_empty || (fifo_count == FCW'(1) && pop));

  for (genvar i = 0; i < MATRIX_SIZE; i++) begin : g_lane
    logic [PSB-1:0]   p;
    logic [REQ_W-1:0] pe;
    assign p         = result_data[i*PSB +: PSB];
    assign pe        = {{(REQ_W-PSB){p[PSB-1]}}, p};
    assign q_next[i] = DATA_BW'(requant(pe, job.shift, DATA_BW));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      job      <= '0;
      acc_cnt  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      busy <= (state == IDLE) ? start : 1'b1;
      done <= (state == DONE);
      case (state)
        IDLE: if (start) begin
          job      <= '{base: base_addr, rows: num_rows, shift: shift};
          overflow <= 1'b0;
          acc_cnt  <= '0;
          state    <= (num_rows == '0) ? DONE : ACTIVE;
        end
        ACTIVE: if (accept) begin
          acc_cnt <= acc_cnt + ROW_ONE;
          if (stall) overflow <= 1'b1;
          if (acc_cnt + ROW_ONE == job.rows) state <= DRAIN;
        end
        DRAIN:   if (drain_empty) state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Quantiser stage: holds its word while the FIFO cannot take it.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_vld  <= 1'b0;
      q_data <= '0;
    end else if (accept && !stall) begin
      q_vld  <= 1'b1;
      q_data <= q_next;
    end else if (push) begin
      q_vld  <= 1'b0;
    end
  end

  sync_fifo #(.WIDTH(WORDSIZE), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (q_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ub_write_enable <= 1'b0;
      ub_address      <= '0;
      ub_data         <= '0;
      wr_idx          <= '0;
    end else begin
      ub_write_enable <= pop;
      if (pop) begin
        ub_address <= job.base + wr_idx;
        ub_data    <= fifo_dout;
      end
      if (launch)   wr_idx <= '0;
      else if (pop) wr_idx <= wr_idx + IDX_ONE;
    end
  end

endmodule

// File: tb/tb_result_writeback.sv
// Self-checking bench: requantisation vectors, address wrap, latency, overflow and reset.
module tb_result_writeback;
  logic         clk = 1'b0;
  logic         rst, start, result_valid, ub_grant;
  logic [9:0]   base_addr;
  logic [10:0]  num_rows;
  logic [4:0]   shift;
  logic [159:0] result_data;
  logic         ub_write_enable, busy, done, overflow;
  logic [9:0]   ub_address;
  logic [63:0]  ub_data;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_writes = 0;

  typedef struct packed { logic [9:0] addr; logic [63:0] data; } wr_t;
  wr_t exp_q[$];
  int  wr_cyc_q[$];

  typedef struct { logic [4:0] sh; int lane[8]; int exp[8]; } vec_t;
  vec_t vt[3];

  result_writeback dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_rows(num_rows),
    .shift(shift), .result_valid(result_valid), .result_data(result_data),
    .ub_grant(ub_grant), .ub_write_enable(ub_write_enable), .ub_address(ub_address),
    .ub_data(ub_data), .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (ub_write_enable) begin
      wr_t e;
      n_writes++;
      wr_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %h data %h expected none", ub_address, ub_data);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(ub_address), 64'(e.addr));
        check("wr_data", ub_data, e.data);
      end
    end
  end

  function automatic logic [159:0] pack_row(input int l[8]);
    logic [159:0] r = '0;
    for (int i = 0; i < 8; i++) r[i*20 +: 20] = l[i][19:0];
    return r;
  endfunction

  function automatic logic [63:0] pack_word(input int b[8]);
    logic [63:0] w = '0;
    for (int i = 0; i < 8; i++) w[i*8 +: 8] = b[i][7:0];
    return w;
  endfunction

  task automatic start_job(input logic [9:0] b, input logic [10:0] n, input logic [4:0] s);
    start = 1'b1; base_addr = b; num_rows = n; shift = s;
    @(negedge clk);
    start = 1'b0;
    check("busy_rise", 64'(busy), 64'd1);
  endtask

  task automatic send_row(input logic [159:0] d);
    result_valid = 1'b1;
    result_data  = d;
    @(negedge clk);
    result_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int dcyc);
    int k = 0;
    while (done !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("done_seen", 64'(done), 64'd1);
    dcyc = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int l[8];
    int dc, c_pre, wb, bcnt, dcnt;

    vt[0].sh = 5'd4;
    vt[0].lane = '{24, 23, -24, 40000, -40000, 8, -8, -9};
    vt[0].exp  = '{2, 1, -1, 127, -128, 1, 0, -1};
    vt[1].sh = 5'd0;
    vt[1].lane = '{127, 128, -128, -129, -1, 0, 100000, -100000};
    vt[1].exp  = '{127, 127, -128, -128, -1, 0, 127, -128};
    vt[2].sh = 5'd19;
    vt[2].lane = '{524287, -524288, 262143, 262144, -262144, -262145, 0, 1};
    vt[2].exp  = '{1, -1, 0, 1, 0, -1, 0, 0};

    rst = 1'b1; start = 1'b0; result_valid = 1'b0; ub_grant = 1'b0;
    base_addr = '0; num_rows = '0; shift = '0; result_data = '0;
    repeat (3) @(negedge clk);
    check("rst_we",   64'(ub_write_enable), 64'd0);
    check("rst_addr", 64'(ub_address), 64'd0);
    check("rst_data", ub_data, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_ovf",  64'(overflow), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Address wrap, latency, throughput and done timing.
    for (int i = 0; i < 8; i++) l[i] = i;
    exp_q.push_back('{10'h3FE, 64'h0706050403020100});
    exp_q.push_back('{10'h3FF, 64'h0706050403020100});
    exp_q.push_back('{10'h000, 64'h0706050403020100});
    exp_q.push_back('{10'h001, 64'h0706050403020100});
    ub_grant = 1'b1;
    start_job(10'h3FE, 11'd4, 5'd0);
    wr_cyc_q.delete();
    c_pre = cyc;
    for (int r = 0; r < 4; r++) send_row(pack_row(l));
    wait_done(30, dc);
    check("t1_nwrites", 64'(wr_cyc_q.size()), 64'd4);
    check("t1_latency", 64'(wr_cyc_q[0]), 64'(c_pre + 3));
    check("t1_thru",    64'(wr_cyc_q[3]), 64'(c_pre + 6));
    check("t1_done_lag", 64'(dc), 64'(c_pre + 7));
    check("t1_busy_at_done", 64'(busy), 64'd1);
    @(negedge clk);
    check("t1_done_pulse", 64'(done), 64'd0);
    check("t1_busy_fall", 64'(busy), 64'd0);
    check("t1_drained", 64'(exp_q.size()), 64'd0);

    // Requantisation vectors, one-row jobs.
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back('{10'(10'h100 + k), pack_word(vt[k].exp)});
      start_job(10'(10'h100 + k), 11'd1, vt[k].sh);
      send_row(pack_row(vt[k].lane));
      wait_done(30, dc);
      @(negedge clk);
      check("vec_drained", 64'(exp_q.size()), 64'd0);
    end

    // Empty job.
    wb = n_writes;
    bcnt = 0; dcnt = 0;
    start = 1'b1; num_rows = 11'd0; base_addr = 10'h010;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (busy) bcnt++;
      if (done) dcnt++;
      @(negedge clk);
    end
    check("zero_busy_cycles", 64'(bcnt), 64'd2);
    check("zero_done_pulses", 64'(dcnt), 64'd1);
    check("zero_no_writes", 64'(n_writes - wb), 64'd0);

    // Overflow: grant withheld while 8 rows arrive.
    ub_grant = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      for (int i = 0; i < 8; i++) l[i] = k*10 + i;
      exp_q.push_back('{10'(10'h200 + k - 1), pack_word(l)});
    end
    wb = n_writes;
    start_job(10'h200, 11'd8, 5'd0);
    for (int k = 1; k <= 8; k++) begin
      for (int i = 0; i < 8; i++) l[i] = k*10 + i;
      send_row(pack_row(l));
    end
    repeat (3) @(negedge clk);
    check("ovf_set", 64'(overflow), 64'd1);
    check("ovf_busy_held", 64'(busy), 64'd1);
    check("ovf_no_write_yet", 64'(n_writes - wb), 64'd0);
    ub_grant = 1'b1;
    wait_done(40, dc);
    check("ovf_nwrites", 64'(n_writes - wb), 64'd5);
    check("ovf_sticky", 64'(overflow), 64'd1);
    check("ovf_drained", 64'(exp_q.size()), 64'd0);
    @(negedge clk);

    // Reset mid-job with two words buffered.
    ub_grant = 1'b0;
    start_job(10'h050, 11'd4, 5'd0);
    check("ovf_cleared", 64'(overflow), 64'd0);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 8; i++) l[i] = 50 + k;
      send_row(pack_row(l));
    end
    rst = 1'b1;
    @(negedge clk);
    check("mrst_we",   64'(ub_write_enable), 64'd0);
    check("mrst_addr", 64'(ub_address), 64'd0);
    check("mrst_data", ub_data, 64'd0);
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_done", 64'(done), 64'd0);
    check("mrst_ovf",  64'(overflow), 64'd0);
    rst = 1'b0;
    ub_grant = 1'b1;
    wb = n_writes;
    repeat (5) @(negedge clk);
    check("mrst_no_stale", 64'(n_writes - wb), 64'd0);
    for (int i = 0; i < 8; i++) l[i] = -3;
    exp_q.push_back('{10'h060, 64'hFDFDFDFDFDFDFDFD});
    exp_q.push_back('{10'h061, 64'hFDFDFDFDFDFDFDFD});
    start_job(10'h060, 11'd2, 5'd0);
    send_row(pack_row(l));
    send_row(pack_row(l));
    wait_done(30, dc);
    check("post_rst_nwrites", 64'(n_writes - wb), 64'd2);
    @(negedge clk);
    check("final_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
